// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI4-Lite arbiter: FSM states, owner id, prot codes.
package axi_arb_pkg;

  localparam int unsigned PROT_W = 3;

  localparam logic [PROT_W-1:0] PROT_INSN = 3'b100;
  localparam logic [PROT_W-1:0] PROT_DATA = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_t;

endpackage

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction outstanding at a time; responses return as one-cycle pulses.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   ifu_req_* / ifu_rsp_*         - fetch request (valid/ready/addr), response pulse + rdata
//   lsu_req_* / lsu_rsp_*         - load/store request (we/addr/wdata/wstrb), response pulse + rdata
//   mem_axi_ar*/r*/aw*/w*/b*      - AXI4-Lite master port toward the memory/MMIO model
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,

  output logic                mem_axi_arvalid,
  input  logic                mem_axi_arready,
  output logic [ADDR_W-1:0]   mem_axi_araddr,
  output logic [PROT_W-1:0]   mem_axi_arprot,

  input  logic                mem_axi_rvalid,
  output logic                mem_axi_rready,
  input  logic [DATA_W-1:0]   mem_axi_rdata,

  output logic                mem_axi_awvalid,
  input  logic                mem_axi_awready,
  output logic [ADDR_W-1:0]   mem_axi_awaddr,
  output logic [PROT_W-1:0]   mem_axi_awprot,

  output logic                mem_axi_wvalid,
  input  logic                mem_axi_wready,
  output logic [DATA_W-1:0]   mem_axi_wdata,
  output logic [DATA_W/8-1:0] mem_axi_wstrb,

  input  logic                mem_axi_bvalid,
  output logic                mem_axi_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  owner_t              owner_q, last_grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                aw_done_q, w_done_q;

  // Latched request payload drives the bus for the whole transaction
  assign mem_axi_araddr = addr_q;
  assign mem_axi_awaddr = addr_q;
  assign mem_axi_wdata  = wdata_q;
  assign mem_axi_wstrb  = wstrb_q;
  assign mem_axi_awprot = PROT_DATA;

  // Grant decision and transaction sequencing
  always_comb begin
    state_d         = state_q;
    ifu_req_ready   = 1'b0;
    lsu_req_ready   = 1'b0;
    mem_axi_arvalid = 1'b0;
    mem_axi_arprot  = PROT_DATA;
    mem_axi_rready  = 1'b0;
    mem_axi_awvalid = 1'b0;
    mem_axi_wvalid  = 1'b0;
    mem_axi_bready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the master not granted last wins; ready is suppressed under reset
        if (!rst) begin
          if (lsu_req_valid && (!ifu_req_valid || last_grant_q == OWN_IFU)) begin
            lsu_req_ready = 1'b1;
            state_d       = lsu_we ? WR_REQ : RD_ADDR;
          end else if (ifu_req_valid) begin
            ifu_req_ready = 1'b1;
            state_d       = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        mem_axi_arvalid = 1'b1;
        mem_axi_arprot  = (owner_q == OWN_IFU) ? PROT_INSN : PROT_DATA;
        if (mem_axi_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        mem_axi_rready = 1'b1;
        if (mem_axi_rvalid) state_d = IDLE;
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together
        mem_axi_awvalid = !aw_done_q;
        mem_axi_wvalid  = !w_done_q;
        if ((aw_done_q || mem_axi_awready) && (w_done_q || mem_axi_wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        mem_axi_bready = 1'b1;
        if (mem_axi_bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, payload latches and response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_IFU;
      last_grant_q  <= OWN_IFU;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
    end else begin
      state_q       <= state_d;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;

      if (lsu_req_ready) begin
        owner_q      <= OWN_LSU;
        last_grant_q <= OWN_LSU;
        addr_q       <= lsu_addr;
        wdata_q      <= lsu_wdata;
        wstrb_q      <= lsu_wstrb;
        aw_done_q    <= 1'b0;
        w_done_q     <= 1'b0;
      end else if (ifu_req_ready) begin
        owner_q      <= OWN_IFU;
        last_grant_q <= OWN_IFU;
        addr_q       <= ifu_addr;
      end

      if (state_q == WR_REQ) begin
        if (mem_axi_awvalid && mem_axi_awready) aw_done_q <= 1'b1;
        if (mem_axi_wvalid && mem_axi_wready)   w_done_q  <= 1'b1;
      end

      if (state_q == RD_DATA && mem_axi_rvalid) begin
        if (owner_q == OWN_IFU) begin
          ifu_rdata     <= mem_axi_rdata;
          ifu_rsp_valid <= 1'b1;
        end else begin
          lsu_rdata     <= mem_axi_rdata;
          lsu_rsp_valid <= 1'b1;
        end
      end

      if (state_q == WR_RESP && mem_axi_bvalid) lsu_rsp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: randomized requesters and slave, transaction-level reference model.
module tb_axi_lite_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } lsu_req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wstrb;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arprot, awprot;
  logic [3:0]  wstrb;

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready)
  );

  int total, bad, cyc;

  // requester side
  logic [31:0] ifu_q[$];
  lsu_req_t    lsu_q[$];
  bit          ifu_pres, lsu_pres;
  logic [31:0] ifu_cur;
  lsu_req_t    lsu_cur;
  int          ifu_gap, lsu_gap, gap_max;

  // reference model: one transaction in flight, memory as a word map
  bit          m_act, m_ar_done, m_aw_done, m_w_done, m_rsp_due, m_rsp_ifu, m_last_ifu, m_fast;
  bit          t_ifu, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_strb;
  int          m_grant_cyc;
  logic [31:0] exp_ifu_rdata, exp_lsu_rdata;
  logic [31:0] ref_mem [bit [29:0]];

  // slave side
  int          max_wait, b_hold, ar_wait, r_wait, aw_wait, w_wait, b_wait;
  bit          r_pend, b_pend, aw_got, w_got;
  logic [31:0] r_data, aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic [31:0] slv_mem [bit [29:0]];
  bit          g_ifu, g_lsu;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_get(input bit [29:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] slv_get(input bit [29:0] k);
    return slv_mem.exists(k) ? slv_mem[k] : 32'h0;
  endfunction

  function automatic int rnd_wait();
    return (max_wait == 0) ? 0 : int'($urandom_range(0, 32'(max_wait)));
  endfunction

  function automatic int rnd_gap();
    return (gap_max == 0) ? 0 : int'($urandom_range(0, 32'(gap_max)));
  endfunction

  task automatic push_ifu(input logic [31:0] a);
    ifu_q.push_back(a);
  endtask

  task automatic push_lsu(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    lsu_req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.strb = s;
    lsu_q.push_back(r);
  endtask

  // One clock: check at negedge, advance model/slave, drive new inputs after posedge
  task automatic step();
    bit rd, wr, ar_hs, r_hs, aw_hs, w_hs, b_hs, e_ifu, e_lsu;
    logic [2:0] exp_prot;
    @(negedge clk);
    cyc++;
    e_lsu = !rst && !m_act && lsu_req_valid && (!ifu_req_valid || m_last_ifu);
    e_ifu = !rst && !m_act && ifu_req_valid && !e_lsu;
    chk("ifu_req_ready", 64'(ifu_req_ready), 64'(e_ifu));
    chk("lsu_req_ready", 64'(lsu_req_ready), 64'(e_lsu));
    chk("ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(m_rsp_due && m_rsp_ifu));
    chk("lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(m_rsp_due && !m_rsp_ifu));
    chk("ifu_rdata", 64'(ifu_rdata), 64'(exp_ifu_rdata));
    chk("lsu_rdata", 64'(lsu_rdata), 64'(exp_lsu_rdata));
    if (m_rsp_due && m_fast) chk("latency", 64'(cyc - m_grant_cyc), 64'(3));

    rd = m_act && !t_we;
    wr = m_act && t_we;
    chk("arvalid", 64'(arvalid), 64'(rd && !m_ar_done));
    chk("rready",  64'(rready),  64'(rd && m_ar_done));
    chk("awvalid", 64'(awvalid), 64'(wr && !m_aw_done));
    chk("wvalid",  64'(wvalid),  64'(wr && !m_w_done));
    chk("bready",  64'(bready),  64'(wr && m_aw_done && m_w_done));
    exp_prot = t_ifu ? 3'b100 : 3'b000;
    if (arvalid) begin
      chk("araddr", 64'(araddr), 64'(t_addr));
      chk("arprot", 64'(arprot), 64'(exp_prot));
    end
    if (awvalid) begin
      chk("awaddr", 64'(awaddr), 64'(t_addr));
      chk("awprot", 64'(awprot), 64'(3'b000));
    end
    if (wvalid) begin
      chk("wdata", 64'(wdata), 64'(t_wdata));
      chk("wstrb", 64'(wstrb), 64'(t_strb));
    end

    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    aw_hs = awvalid && awready;
    w_hs  = wvalid && wready;
    b_hs  = bvalid && bready;
    g_ifu = e_ifu;
    g_lsu = e_lsu;

    if (rst) begin
      m_act = 0; m_rsp_due = 0; m_last_ifu = 1;
      exp_ifu_rdata = '0; exp_lsu_rdata = '0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    end else begin
      // slave
      if (r_hs) r_pend = 0;
      else if (r_pend && r_wait > 0) r_wait--;
      if (arvalid && !arready && ar_wait > 0) ar_wait--;
      if (ar_hs) begin
        r_pend = 1; r_wait = rnd_wait(); r_data = slv_get(araddr[31:2]); ar_wait = rnd_wait();
      end
      if (awvalid && !awready && aw_wait > 0) aw_wait--;
      if (aw_hs) begin aw_got = 1; aw_addr_s = awaddr; aw_wait = rnd_wait(); end
      if (wvalid && !wready && w_wait > 0) w_wait--;
      if (w_hs) begin w_got = 1; w_data_s = wdata; w_strb_s = wstrb; w_wait = rnd_wait(); end
      if (b_hs) begin
        slv_mem[aw_addr_s[31:2]] = merge(slv_get(aw_addr_s[31:2]), w_data_s, w_strb_s);
        b_pend = 0; aw_got = 0; w_got = 0;
      end else if (b_pend && b_wait > 0) b_wait--;
      else if (aw_got && w_got && !b_pend) begin b_pend = 1; b_wait = rnd_wait() + b_hold; end

      // model
      m_rsp_due = 0;
      if (ar_hs) m_ar_done = 1;
      if (aw_hs) m_aw_done = 1;
      if (w_hs)  m_w_done  = 1;
      if (m_act && (r_hs || b_hs)) begin
        if (t_we) ref_mem[t_addr[31:2]] = merge(ref_get(t_addr[31:2]), t_wdata, t_strb);
        else if (t_ifu) exp_ifu_rdata = ref_get(t_addr[31:2]);
        else exp_lsu_rdata = ref_get(t_addr[31:2]);
        m_rsp_due = 1; m_rsp_ifu = t_ifu; m_act = 0;
      end
      if (e_ifu || e_lsu) begin
        m_act = 1; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
        m_last_ifu = e_ifu; m_grant_cyc = cyc;
        t_ifu   = e_ifu;
        t_we    = e_lsu && lsu_we;
        t_addr  = e_ifu ? ifu_addr : lsu_addr;
        t_wdata = lsu_wdata;
        t_strb  = lsu_wstrb;
        m_fast  = (max_wait == 0 && b_hold == 0 && ar_wait == 0 && aw_wait == 0 && w_wait == 0);
      end
    end

    @(posedge clk);
    #1;
    if (g_ifu) begin ifu_pres = 0; ifu_gap = rnd_gap(); end
    if (g_lsu) begin lsu_pres = 0; lsu_gap = rnd_gap(); end
    if (!ifu_pres) begin
      if (ifu_gap > 0) ifu_gap--;
      else if (ifu_q.size() > 0) begin ifu_pres = 1; ifu_cur = ifu_q.pop_front(); end
    end
    if (!lsu_pres) begin
      if (lsu_gap > 0) lsu_gap--;
      else if (lsu_q.size() > 0) begin lsu_pres = 1; lsu_cur = lsu_q.pop_front(); end
    end
    ifu_req_valid = ifu_pres;
    ifu_addr      = ifu_cur;
    lsu_req_valid = lsu_pres;
    lsu_we        = lsu_cur.we;
    lsu_addr      = lsu_cur.addr;
    lsu_wdata     = lsu_cur.wdata;
    lsu_wstrb     = lsu_cur.strb;
    arready = (ar_wait == 0);
    rvalid  = r_pend && (r_wait == 0);
    rdata   = r_data;
    awready = (aw_wait == 0);
    wready  = (w_wait == 0);
    bvalid  = b_pend && (b_wait == 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((ifu_q.size() > 0 || lsu_q.size() > 0 || ifu_pres || lsu_pres || m_act || m_rsp_due) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(n < budget), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st_addr;
    total = 0; bad = 0; cyc = 0;
    ifu_pres = 0; lsu_pres = 0; ifu_gap = 0; lsu_gap = 0; gap_max = 0;
    ifu_cur = '0; lsu_cur = '0;
    m_act = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0; m_rsp_due = 0; m_rsp_ifu = 0;
    m_last_ifu = 1; m_fast = 0; m_grant_cyc = 0;
    t_ifu = 0; t_we = 0; t_addr = '0; t_wdata = '0; t_strb = '0;
    exp_ifu_rdata = '0; exp_lsu_rdata = '0;
    max_wait = 0; b_hold = 0; ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    r_data = '0; aw_addr_s = '0; w_data_s = '0; w_strb_s = '0;
    st_addr = 32'h8000_1000;

    slv_mem[30'h2000_0000] = 32'h0000_0413; ref_mem[30'h2000_0000] = 32'h0000_0413;
    slv_mem[30'h2800_0012] = 32'h1234_5678; ref_mem[30'h2800_0012] = 32'h1234_5678;
    slv_mem[st_addr[31:2]] = 32'h1111_2222; ref_mem[st_addr[31:2]] = 32'h1111_2222;

    rst = 1;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    arready = 1; rvalid = 0; rdata = '0; awready = 1; wready = 1; bvalid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ifu_req_ready", 64'(ifu_req_ready), 64'(0));
    chk("rst_lsu_req_ready", 64'(lsu_req_ready), 64'(0));
    chk("rst_ifu_rsp_valid", 64'(ifu_rsp_valid), 64'(0));
    chk("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'(0));
    chk("rst_ifu_rdata", 64'(ifu_rdata), 64'(0));
    chk("rst_lsu_rdata", 64'(lsu_rdata), 64'(0));
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("rst_arprot", 64'(arprot), 64'(0));
    chk("rst_rready", 64'(rready), 64'(0));
    chk("rst_awvalid", 64'(awvalid), 64'(0));
    chk("rst_awaddr", 64'(awaddr), 64'(0));
    chk("rst_awprot", 64'(awprot), 64'(0));
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("rst_wstrb", 64'(wstrb), 64'(0));
    chk("rst_bready", 64'(bready), 64'(0));
    @(posedge clk);
    #1 rst = 0;

    // zero-wait fetch
    push_ifu(32'h8000_0000);
    drain("fetch_timeout", 50);
    chk("fetch_rdata", 64'(ifu_rdata), 64'(32'h0000_0413));

    // both masters contend back-to-back: grants must alternate starting with LSU
    for (int i = 0; i < 4; i++) begin
      push_ifu(32'h8000_0000 + 32'(i * 4));
      push_lsu(1'b0, 32'h8000_0020 + 32'(i * 4), 32'h0, 4'h0);
    end
    drain("tie_timeout", 100);

    // store where AW completes two cycles before W
    aw_wait = 0; w_wait = 2;
    push_lsu(1'b1, st_addr, 32'hDEAD_BEEF, 4'b0011);
    drain("store_timeout", 50);
    chk("store_mem", 64'(slv_get(st_addr[31:2])), 64'(32'h1111_BEEF));

    // slave stalls AR for 5 cycles while LSU also wants the bus
    ar_wait = 5;
    push_ifu(32'h8000_0004);
    step();
    push_lsu(1'b0, 32'h8000_0008, 32'h0, 4'h0);
    drain("stall_timeout", 60);

    // MMIO load from RTC low word
    push_lsu(1'b0, 32'hA000_0048, 32'h0, 4'h0);
    drain("load_timeout", 50);
    chk("load_rdata", 64'(lsu_rdata), 64'(32'h1234_5678));

    // reset while waiting for B; the aborted write must not issue a response
    b_hold = 8;
    push_lsu(1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'hF);
    for (int n = 0; n < 40 && !(m_act && t_we && m_aw_done && m_w_done); n++) step();
    chk("reach_wr_resp", 64'(m_act && t_we && m_aw_done && m_w_done), 64'(1));
    rst = 1;
    step();
    rst = 0;
    b_hold = 0;
    repeat (3) step();
    push_ifu(32'h8000_0010);
    drain("post_rst_timeout", 50);

    // randomized traffic
    max_wait = 3; gap_max = 3;
    for (int i = 0; i < 40; i++) begin
      push_ifu(32'h8000_0000 | (32'($urandom_range(0, 15)) << 2));
      push_lsu(1'($urandom_range(0, 1)), 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2),
               $urandom, 4'($urandom_range(1, 15)));
    end
    drain("random_timeout", 4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
